// File: rtl/ita_step_scheduler_if.sv
// -----------------------------------------------------------------------------
// ita_step_scheduler_if
//
// Purpose:
//   Tile command / completion bundle between the step scheduler (master) and
//   the datapath step/tile controller (slave).
//
// Signals:
//   cmd_valid  master->slave  tile command valid
//   cmd_ready  slave->master  datapath accepts the command this cycle
//   cmd_step   master->slave  step code (0 when no command is offered)
//   cmd_tile   master->slave  tile index within the current step
//   cmd_head   master->slave  current attention head
//   tile_done  slave->master  one tile completed (single-cycle pulse)
//
// Parameters:
//   H      max number of heads (sets cmd_head width)
//   TileW  tile index width
// -----------------------------------------------------------------------------
interface ita_step_scheduler_if #(
    parameter int H     = 1,
    parameter int TileW = 32
);
    localparam int HeadW = (H > 1) ? $clog2(H) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_step;
    logic [TileW-1:0] cmd_tile;
    logic [HeadW-1:0] cmd_head;
    logic             tile_done;

    modport master (
        output cmd_valid,
        output cmd_step,
        output cmd_tile,
        output cmd_head,
        input  cmd_ready,
        input  tile_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_step,
        input  cmd_tile,
        input  cmd_head,
        output cmd_ready,
        output tile_done
    );
endinterface

// File: rtl/ita_step_scheduler.sv
// -----------------------------------------------------------------------------
// ita_step_scheduler
//
// Purpose:
//   Walks the accelerator datapath through the computation steps of one layer
//   invocation. Attention runs Q, K, V, QK, AV, OW for every head; feedforward
//   runs a single FF step. One tile command is issued per handshake, the number
//   of issued-but-uncompleted tiles is bounded, and every step is separated by
//   a barrier that waits for all of its tiles to complete.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       start pulse, only looked at while idle
//   layer_i       0 = attention, 1 = feedforward
//   n_heads_i     number of heads to process (clamped to H)
//   lin_tiles_i   tiles per Q/K/V/OW/FF step
//   attn_tiles_i  tiles per QK/AV step
//   cmd_if        master side of the tile command / completion bundle
//   busy_o        high from the accepted start until completion
//   done_o        one-cycle pulse at layer completion
//   err_o         sticky: a tile completion arrived with nothing outstanding
//
// Parameters:
//   H               max number of heads supported
//   TileW           tile count / index width
//   MaxOutstanding  max issued-but-uncompleted tiles (>= 1)
//
// Optional feature (macro ITA_SCHED_PERF_EN):
//   perf_busy_cycles_o   cycles with busy_o high
//   perf_stall_cycles_o  cycles with a command offered but not accepted
//   Both clear on an accepted start, saturate, and hold after completion.
// -----------------------------------------------------------------------------
module ita_step_scheduler #(
    parameter int  H              = 1,
    parameter int  TileW          = 32,
    parameter int  MaxOutstanding = 4,
    localparam int NHeadsW        = $clog2(H + 1),
    localparam int HeadW          = (H > 1) ? $clog2(H) : 1,
    localparam int OutW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 layer_i,
    input  logic [NHeadsW-1:0]   n_heads_i,
    input  logic [TileW-1:0]     lin_tiles_i,
    input  logic [TileW-1:0]     attn_tiles_i,
    ita_step_scheduler_if.master cmd_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
`ifdef ITA_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_busy_cycles_o,
    output logic [31:0]          perf_stall_cycles_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        STEP_IDLE = 3'd0,
        STEP_Q    = 3'd1,
        STEP_K    = 3'd2,
        STEP_V    = 3'd3,
        STEP_QK   = 3'd4,
        STEP_AV   = 3'd5,
        STEP_OW   = 3'd6,
        STEP_FF   = 3'd7
    } step_e;

    typedef enum logic {
        LAYER_ATTN = 1'b0,
        LAYER_FF   = 1'b1
    } layer_e;

    state_e             state_q, state_d;
    step_e              step_q, step_d;
    layer_e             layer_q, layer_d;
    logic [HeadW-1:0]   head_q, head_d;
    logic [TileW-1:0]   tile_q, tile_d;
    logic [OutW-1:0]    outst_q, outst_d;
    logic [NHeadsW-1:0] n_heads_q, n_heads_d;
    logic [TileW-1:0]   lin_q, lin_d;
    logic [TileW-1:0]   attn_q, attn_d;
    logic               err_q, err_d;

    logic               cmd_valid;
    logic               fire;
    logic               done_valid;
    logic [TileW-1:0]   step_count;
    logic               last_tile;
    logic [NHeadsW-1:0] n_heads_clamped;
    logic [NHeadsW-1:0] head_inc;
    logic [2:0]         next_in_head;
    logic [2:0]         first_of_head;
    logic [2:0]         first_on_start;

    // Lowest attention step code >= from whose tile count is non-zero, or 0
    // when none is left in the head. This is how empty steps get skipped
    // without spending any cycles on them.
    function automatic logic [2:0] first_step(input logic [2:0] from,
                                              input logic       lin_nz,
                                              input logic       attn_nz);
        logic [2:0] found;
        found = 3'd0;
        for (int s = 6; s >= 1; s--) begin
            if (3'(s) >= from) begin
                if ((s == 4 || s == 5) ? attn_nz : lin_nz) begin
                    found = 3'(s);
                end
            end
        end
        return found;
    endfunction

    // Commands are only offered while the in-flight window has room.
    assign cmd_valid  = (state_q == ST_ISSUE) && (outst_q < OutW'(MaxOutstanding));
    assign fire       = cmd_valid && cmd_if.cmd_ready;
    assign done_valid = cmd_if.tile_done && (outst_q != '0);

    assign step_count = ((step_q == STEP_QK) || (step_q == STEP_AV)) ? attn_q : lin_q;
    assign last_tile  = (tile_q == step_count - TileW'(1));

    assign n_heads_clamped = (n_heads_i > NHeadsW'(H)) ? NHeadsW'(H) : n_heads_i;
    assign head_inc        = NHeadsW'(head_q) + NHeadsW'(1);

    assign next_in_head   = first_step(step_q + 3'd1, lin_q != '0, attn_q != '0);
    assign first_of_head  = first_step(3'(STEP_Q), lin_q != '0, attn_q != '0);
    assign first_on_start = first_step(3'(STEP_Q), lin_tiles_i != '0, attn_tiles_i != '0);

    // Next-state logic: sequencing FSM plus the outstanding-tile bookkeeping.
    // The drain barrier looks at outst_d so the next step can start one
    // cycle after the final completion instead of two.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        layer_d   = layer_q;
        head_d    = head_q;
        tile_d    = tile_q;
        outst_d   = outst_q;
        n_heads_d = n_heads_q;
        lin_d     = lin_q;
        attn_d    = attn_q;
        err_d     = err_q;

        unique case ({fire, done_valid})
            2'b10:   outst_d = outst_q + OutW'(1);
            2'b01:   outst_d = outst_q - OutW'(1);
            default: outst_d = outst_q;
        endcase

        if (cmd_if.tile_done && (outst_q == '0)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    layer_d   = layer_e'(layer_i);
                    n_heads_d = n_heads_clamped;
                    lin_d     = lin_tiles_i;
                    attn_d    = attn_tiles_i;
                    head_d    = '0;
                    tile_d    = '0;
                    if (layer_e'(layer_i) == LAYER_FF) begin
                        if (lin_tiles_i != '0) begin
                            step_d  = STEP_FF;
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if ((n_heads_clamped == '0) || (first_on_start == 3'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_e'(first_on_start);
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (fire) begin
                    if (last_tile) begin
                        tile_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        tile_d = tile_q + TileW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (outst_d == '0) begin
                    if (layer_q == LAYER_FF) begin
                        state_d = ST_DONE;
                    end else if (next_in_head != 3'd0) begin
                        step_d  = step_e'(next_in_head);
                        state_d = ST_ISSUE;
                    end else if (head_inc < n_heads_q) begin
                        // A non-empty head exists, so the next one has a step too.
                        head_d  = head_q + HeadW'(1);
                        step_d  = step_e'(first_of_head);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                step_d  = STEP_IDLE;
                head_d  = '0;
                tile_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched configuration registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            step_q    <= STEP_IDLE;
            layer_q   <= LAYER_ATTN;
            head_q    <= '0;
            tile_q    <= '0;
            outst_q   <= '0;
            n_heads_q <= '0;
            lin_q     <= '0;
            attn_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            layer_q   <= layer_d;
            head_q    <= head_d;
            tile_q    <= tile_d;
            outst_q   <= outst_d;
            n_heads_q <= n_heads_d;
            lin_q     <= lin_d;
            attn_q    <= attn_d;
            err_q     <= err_d;
        end
    end

    // The step code reads as idle whenever no command is being offered.
    assign cmd_if.cmd_valid = cmd_valid;
    assign cmd_if.cmd_step  = cmd_valid ? step_q : STEP_IDLE;
    assign cmd_if.cmd_tile  = tile_q;
    assign cmd_if.cmd_head  = head_q;

    assign busy_o = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;

`ifdef ITA_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating counters; they only advance while busy, so they naturally
    // hold their final values once the layer completes.
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == ST_IDLE) && start_i) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy_o && (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (cmd_valid && !cmd_if.cmd_ready && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ita_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ita_step_scheduler
//
// Scoreboard bench for ita_step_scheduler. Each layer start pushes its full
// expected command sequence; a datapath responder accepts commands, schedules
// completions and pops/compares every accepted command.
// -----------------------------------------------------------------------------
module tb_ita_step_scheduler;

    localparam int H       = 2;
    localparam int TileW   = 32;
    localparam int MaxOut  = 4;
    localparam int NHeadsW = $clog2(H + 1);

    typedef struct packed {
        logic [2:0]  step;
        logic [31:0] tile;
        logic [7:0]  head;
    } cmd_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               layer;
    logic [NHeadsW-1:0] nHeads;
    logic [TileW-1:0]   linTiles;
    logic [TileW-1:0]   attnTiles;
    logic               busy;
    logic               done;
    logic               err;
`ifdef ITA_SCHED_PERF_EN
    logic [31:0]        perfBusy;
    logic [31:0]        perfStall;
`endif

    ita_step_scheduler_if #(.H(H), .TileW(TileW)) cmdIf ();

    ita_step_scheduler #(
        .H              (H),
        .TileW          (TileW),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .start_i             (start),
        .layer_i             (layer),
        .n_heads_i           (nHeads),
        .lin_tiles_i         (linTiles),
        .attn_tiles_i        (attnTiles),
        .cmd_if              (cmdIf),
        .busy_o              (busy),
        .done_o              (done),
        .err_o               (err)
`ifdef ITA_SCHED_PERF_EN
        ,
        .perf_busy_cycles_o  (perfBusy),
        .perf_stall_cycles_o (perfStall)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    cmd_t expQ[$];
    int   pending[$];
    int   cycle = 0;
    int   fires = 0;
    int   doneCount = 0;
    int   busyCount = 0;
    int   outModel = 0;
    int   doneDelay = 2;
    logic holdDone = 1'b0;
    logic forceOne = 1'b0;
    logic spuriousDone = 1'b0;
    logic prevDone = 1'b0;
    logic stallArmed = 1'b0;
    logic firstStall = 1'b0;
    logic [2:0] stallStep = 3'd0;
    int   stallTile = 0;
    int   stallLen = 0;
    int   stallLeft = 0;
    logic [2:0]  snapStep;
    logic [31:0] snapTile;
    logic [7:0]  snapHead;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push the expected command sequence for one layer, then pulse start.
    task automatic applyStimulus(input logic lay, input int nh, input int lin, input int attn);
        cmd_t c;
        int   cnt;
        if (lay) begin
            for (int t = 0; t < lin; t++) begin
                c.step = 3'd7; c.tile = 32'(t); c.head = 8'd0;
                expQ.push_back(c);
            end
        end else begin
            for (int h = 0; h < nh; h++) begin
                for (int s = 1; s <= 6; s++) begin
                    cnt = (s == 4 || s == 5) ? attn : lin;
                    for (int t = 0; t < cnt; t++) begin
                        c.step = 3'(s); c.tile = 32'(t); c.head = 8'(h);
                        expQ.push_back(c);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        layer     = lay;
        nHeads    = NHeadsW'(nh);
        linTiles  = TileW'(lin);
        attnTiles = TileW'(attn);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finishLayer(input string tag, input int d0, input int bound);
        int n;
        n = 0;
        while (doneCount == d0 && n < bound) begin
            waitCycles(1);
            n++;
        end
        waitCycles(3);
        checkOutput({tag, "DoneOnce"}, 64'(doneCount - d0), 64'd1);
        checkOutput({tag, "BusyLow"}, 64'(busy), 64'd0);
        checkOutput({tag, "QueueEmpty"}, 64'(expQ.size()), 64'd0);
    endtask

    // Datapath responder and scoreboard monitor, acting on the falling edge.
    initial begin
        cmd_t e;
        cmdIf.cmd_ready = 1'b0;
        cmdIf.tile_done = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                cmdIf.cmd_ready = 1'b0;
                cmdIf.tile_done = 1'b0;
                pending.delete();
                outModel  = 0;
                stallLeft = 0;
                prevDone  = 1'b0;
            end else begin
                if (done) begin
                    doneCount++;
                    checkOutput("doneBusyLow", 64'(busy), 64'd0);
                    checkOutput("donePulseWidth", 64'(prevDone), 64'd0);
                end
                prevDone = done;
                if (busy) busyCount++;
                if (outModel == MaxOut) checkOutput("outstandingCap", 64'(cmdIf.cmd_valid), 64'd0);

                if (stallArmed && cmdIf.cmd_valid && cmdIf.cmd_step == stallStep &&
                    cmdIf.cmd_tile == 32'(stallTile)) begin
                    stallArmed = 1'b0;
                    stallLeft  = stallLen;
                    firstStall = 1'b1;
                    snapStep   = cmdIf.cmd_step;
                    snapTile   = cmdIf.cmd_tile;
                    snapHead   = 8'(cmdIf.cmd_head);
                end
                if (stallLeft > 0) begin
                    if (!firstStall) begin
                        checkOutput("stallValid", 64'(cmdIf.cmd_valid), 64'd1);
                        checkOutput("stallStep", 64'(cmdIf.cmd_step), 64'(snapStep));
                        checkOutput("stallTile", 64'(cmdIf.cmd_tile), 64'(snapTile));
                        checkOutput("stallHead", 64'(cmdIf.cmd_head), 64'(snapHead));
                    end
                    firstStall = 1'b0;
                    stallLeft--;
                    cmdIf.cmd_ready = 1'b0;
                end else begin
                    cmdIf.cmd_ready = 1'b1;
                end

                cmdIf.tile_done = 1'b0;
                if (spuriousDone) begin
                    cmdIf.tile_done = 1'b1;
                    spuriousDone = 1'b0;
                end else if (pending.size() > 0 &&
                             (forceOne || (!holdDone && pending[0] <= cycle))) begin
                    cmdIf.tile_done = 1'b1;
                    void'(pending.pop_front());
                    forceOne = 1'b0;
                    outModel--;
                end

                if (cmdIf.cmd_valid && cmdIf.cmd_ready) begin
                    fires++;
                    outModel++;
                    pending.push_back(cycle + doneDelay);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedCmd", 64'(cmdIf.cmd_valid), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("cmdStep", 64'(cmdIf.cmd_step), 64'(e.step));
                        checkOutput("cmdTile", 64'(cmdIf.cmd_tile), 64'(e.tile));
                        checkOutput("cmdHead", 64'(cmdIf.cmd_head), 64'(e.head));
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        int f0;
        int b0;
        int n;
        rst_n = 1'b0; start = 1'b0; layer = 1'b0;
        nHeads = '0; linTiles = '0; attnTiles = '0;

        // Reset values while rst_n is held low.
        waitCycles(2);
        checkOutput("rstValid", 64'(cmdIf.cmd_valid), 64'd0);
        checkOutput("rstStep", 64'(cmdIf.cmd_step), 64'd0);
        checkOutput("rstTile", 64'(cmdIf.cmd_tile), 64'd0);
        checkOutput("rstHead", 64'(cmdIf.cmd_head), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] attention, one head, lin=2 attn=3");
        doneDelay = 2;
        d0 = doneCount;
        applyStimulus(1'b0, 1, 2, 3);
        checkOutput("t1LatencyValid", 64'(cmdIf.cmd_valid), 64'd1);
        checkOutput("t1LatencyBusy", 64'(busy), 64'd1);
        finishLayer("t1", d0, 200);

        $display("[TB] feedforward, lin=5, completions withheld");
        d0 = doneCount;
        f0 = fires;
        holdDone = 1'b1;
        applyStimulus(1'b1, 1, 5, 0);
        waitCycles(10);
        checkOutput("t2FourFires", 64'(fires - f0), 64'd4);
        checkOutput("t2ValidLow", 64'(cmdIf.cmd_valid), 64'd0);
        forceOne = 1'b1;
        waitCycles(3);
        checkOutput("t2FifthFire", 64'(fires - f0), 64'd5);
        waitCycles(4);
        checkOutput("t2DrainBusy", 64'(busy), 64'd1);
        checkOutput("t2NoEarlyDone", 64'(doneCount - d0), 64'd0);
        holdDone = 1'b0;
        finishLayer("t2", d0, 100);

        $display("[TB] attention, two heads, attn=0 lin=1");
        d0 = doneCount;
        applyStimulus(1'b0, 2, 1, 0);
        finishLayer("t3", d0, 200);

        $display("[TB] ready stall on K tile 1, completions overlap issues");
        doneDelay  = 4;
        stallStep  = 3'd2;
        stallTile  = 1;
        stallLen   = 3;
        stallArmed = 1'b1;
        d0 = doneCount;
        applyStimulus(1'b0, 1, 6, 1);
        finishLayer("t4", d0, 400);
        checkOutput("t4StallHit", 64'(stallArmed), 64'd0);
        doneDelay = 2;

        $display("[TB] reset mid-AV, spurious completion, start while busy");
        d0 = doneCount;
        applyStimulus(1'b0, 1, 2, 3);
        n = 0;
        while (cmdIf.cmd_step != 3'd5 && n < 200) begin
            waitCycles(1);
            n++;
        end
        checkOutput("t5ReachAV", 64'(cmdIf.cmd_step), 64'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("t5RstValid", 64'(cmdIf.cmd_valid), 64'd0);
        checkOutput("t5RstStep", 64'(cmdIf.cmd_step), 64'd0);
        checkOutput("t5RstTile", 64'(cmdIf.cmd_tile), 64'd0);
        checkOutput("t5RstHead", 64'(cmdIf.cmd_head), 64'd0);
        checkOutput("t5RstBusy", 64'(busy), 64'd0);
        checkOutput("t5RstDone", 64'(done), 64'd0);
        expQ.delete();
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("t5ErrFresh", 64'(err), 64'd0);
        spuriousDone = 1'b1;
        waitCycles(2);
        checkOutput("t5ErrSet", 64'(err), 64'd1);
        d0 = doneCount;
        applyStimulus(1'b1, 1, 2, 0);
        waitCycles(1);
        start     = 1'b1;
        layer     = 1'b0;
        nHeads    = NHeadsW'(2);
        linTiles  = TileW'(4);
        attnTiles = TileW'(4);
        waitCycles(1);
        start = 1'b0;
        finishLayer("t5", d0, 100);
        checkOutput("t5ErrSticky", 64'(err), 64'd1);
        checkOutput("t5NoRestart", 64'(cmdIf.cmd_valid), 64'd0);

`ifdef ITA_SCHED_PERF_EN
        $display("[TB] performance counters, FF lin=3 with two stall cycles");
        stallStep  = 3'd7;
        stallTile  = 1;
        stallLen   = 2;
        stallArmed = 1'b1;
        d0 = doneCount;
        b0 = busyCount;
        applyStimulus(1'b1, 1, 3, 0);
        finishLayer("perf", d0, 100);
        checkOutput("perfStall", 64'(perfStall), 64'd2);
        checkOutput("perfBusy", 64'(perfBusy), 64'(busyCount - b0));
`else
        b0 = busyCount;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_step_scheduler.md
Name: ita_step_scheduler

Overview:
- Sequences the accelerator datapath through its computation steps for one layer invocation.
- Attention layer: steps Q, K, V, QK, AV, OW, repeated per head. Feedforward layer: a single FF step.
- Issues one tile command per handshake, bounds the number of in-flight tiles, and barriers between steps.
- Sits between the control/config register interface and the datapath step/tile controller.

Parameters:
- H, 1, max number of heads supported.
- TileW, 32, tile count width (matches tile_t).
- MaxOutstanding, 4, max issued-but-uncompleted tiles (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- layer_i  in  1  0=Attention, 1=Feedforward (layer_e encoding)
- n_heads_i  in  idx_width(H+1)  heads to process
- lin_tiles_i  in  TileW  tiles per Q/K/V/OW/FF step
- attn_tiles_i  in  TileW  tiles per QK/AV step
- cmd_valid_o  out  1  tile command valid
- cmd_ready_i  in  1  datapath accepts command
- cmd_step_o  out  3  step_e code (Q=1..FF=7; Idle=0 when no command)
- cmd_tile_o  out  TileW  tile index within step
- cmd_head_o  out  idx_width(H)  current head
- tile_done_i  in  1  one tile completed (pulse)
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse at layer completion
- err_o  out  1  sticky: tile_done_i with zero outstanding

Behaviour:
- Reset (async, any time incl. mid-operation): FSM=IDLE, all counters 0, cmd_valid_o=0, cmd_step_o=0, cmd_tile_o=0, cmd_head_o=0, busy_o=0, done_o=0, err_o=0. In-flight datapath completions after reset are not the scheduler's concern; err_o counts as fresh.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start_i, latch layer_i, n_heads_i, lin_tiles_i, attn_tiles_i; busy_o=1 next cycle; select first step (Q, head 0, or FF). If n_heads_i==0 on an Attention start, go to DONE.
- Step tile count: Q/K/V/OW/FF use lin_tiles; QK/AV use attn_tiles. Steps with count 0 are skipped combinationally in the step-advance logic, at most one cycle per skipped step.
- ISSUE:
  - cmd_valid_o=1 while outstanding<MaxOutstanding; command fires when cmd_valid_o & cmd_ready_i.
  - On fire: tile index+1, outstanding+1.
  - Once tile index==count-1 fires, go to DRAIN.
  - cmd_step/tile/head are stable while cmd_valid_o && !cmd_ready_i.
- DRAIN: cmd_valid_o=0; wait until outstanding==0, then advance to next step and go to ISSUE, or to DONE after the last step.
- Step order, Attention: per head h=0..n_heads-1: Q,K,V,QK,AV,OW; head+1 after OW. Feedforward: FF only.
- DONE: done_o=1 for exactly one cycle, busy_o=0 in the same cycle, then IDLE. Back-to-back start is accepted the following cycle.
- Outstanding counter:
  - fire and tile_done_i in the same cycle: unchanged.
  - tile_done_i at 0: counter stays 0, err_o set (sticky until reset).
- start_i while busy is ignored; latched config is immutable during an operation.
- Tile index counter is TileW bits; count up to 2^TileW-1 with no wrap before step end.
- Latency: start to first cmd_valid_o = 1 cycle. Last tile_done_i to next step's cmd_valid_o = 1 cycle.

Optional Feature:
- Macro ITA_SCHED_PERF_EN.
- When defined, add outputs:
  - perf_busy_cycles_o [31:0]: cycles with busy_o=1.
  - perf_stall_cycles_o [31:0]: cycles with cmd_valid_o & !cmd_ready_i.
- Both cleared on accepted start, saturate at 2^32-1, hold after done.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Attention, n_heads=1, lin=2, attn=3, ready=1, done 2 cycles after fire → command sequence Q0,Q1,K0,K1,V0,V1,QK0-2,AV0-2,OW0,OW1; exactly one done_o pulse; busy_o low after.
- Feedforward, lin=5, MaxOutstanding=4, tile_done_i withheld → 4 fires then cmd_valid_o=0. One tile_done_i → fifth fire. DRAIN waits for 5 completions.
- Attention, n_heads=2, attn=0, lin=1 → QK/AV skipped; sequence Q,K,V,OW per head with cmd_head_o 0 then 1; done_o pulse.
- cmd_ready_i=0 for 3 cycles on K tile 1 → outputs stable during stall; fire and tile_done_i in the same cycle keep outstanding constant.
- Assert rst_ni low mid-AV, and tile_done_i while idle → all outputs reset immediately; err_o=1 after the spurious done; start_i pulsed while busy is ignored.
- Perf macro defined, FF lin=3 with 2 stall cycles → perf_stall_cycles_o=2 and perf_busy_cycles_o equals the measured busy_o-high count.
